// File: rtl/op_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// op_sequencer : fetch/decode/execute sequencer driving the datapath control word
// Rev 1.0
// ---------------------------------------------------------------------------
module op_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [7:0]      ctrl,
  output logic            ctrl_valid,
  output logic [5:0]      operand,
  input  logic            exec_done,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  localparam logic [7:0] c_CTRL_OP0  = 8'h0B;
  localparam logic [7:0] c_CTRL_OP1  = 8'h66;
  localparam logic [7:0] c_CTRL_OP2  = 8'h14;
  localparam logic [7:0] c_CTRL_HALT = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_ir;
  logic [7:0]      w_ir_next;
  logic [PC_W-1:0] w_pc_next;
  logic [7:0]      w_ctrl_next;
  logic            w_ctrl_valid_next;
  logic [5:0]      w_operand_next;

  function automatic logic [7:0] f_decode(input logic [1:0] op);
    logic [7:0] v;
    case (op)
      2'b00:   v = c_CTRL_OP0;
      2'b01:   v = c_CTRL_OP1;
      2'b10:   v = c_CTRL_OP2;
      default: v = c_CTRL_HALT;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_ir_next         = r_ir;
    w_pc_next         = pc;
    w_ctrl_next       = ctrl;
    w_ctrl_valid_next = ctrl_valid;
    w_operand_next    = operand;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_ir_next    = imem_data;
          w_pc_next    = pc + PC_W'(1);
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_ctrl_next    = f_decode(r_ir[7:6]);
        w_operand_next = r_ir[5:0];
        if (r_ir[7:6] == 2'b11) begin
          w_ctrl_valid_next = 1'b0;
          w_state_next      = ST_HALT;
        end else begin
          w_ctrl_valid_next = 1'b1;
          w_state_next      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          w_ctrl_next       = 8'h00;
          w_ctrl_valid_next = 1'b0;
          w_state_next      = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (start) begin
          w_pc_next    = '0;
          w_ctrl_next  = 8'h00;
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= 8'h00;
      pc         <= '0;
      imem_addr  <= '0;
      imem_req   <= 1'b0;
      ctrl       <= 8'h00;
      ctrl_valid <= 1'b0;
      operand    <= 6'd0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      r_ir       <= w_ir_next;
      pc         <= w_pc_next;
      imem_addr  <= w_pc_next;
      imem_req   <= (w_state_next == ST_FETCH);
      ctrl       <= w_ctrl_next;
      ctrl_valid <= w_ctrl_valid_next;
      operand    <= w_operand_next;
      busy       <= (w_state_next == ST_FETCH) || (w_state_next == ST_DECODE) ||
                    (w_state_next == ST_EXEC);
      halted     <= (w_state_next == ST_HALT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_op_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_op_sequencer : directed bench with an instruction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [7:0] ctrl;
  logic       ctrl_valid;
  logic [5:0] operand;
  logic       exec_done = 1'b0;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  int checks = 0;
  int errors = 0;

  op_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ctrl(ctrl), .ctrl_valid(ctrl_valid), .operand(operand), .exec_done(exec_done),
    .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 exec, 4 halt
  int         m_phase;
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  logic [1:0] m_op;
  logic [5:0] m_operand;

  function automatic logic [7:0] ctrl_word(input logic [1:0] op);
    logic [7:0] tbl [4];
    tbl[0] = 8'h0B; tbl[1] = 8'h66; tbl[2] = 8'h14; tbl[3] = 8'h80;
    return tbl[op];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_pc <= 8'h00; m_ir <= 8'h00; m_op <= 2'd0; m_operand <= 6'd0;
    end else begin
      case (m_phase)
        0: if (start) m_phase <= 1;
        1: if (imem_ack) begin m_ir <= imem_data; m_pc <= m_pc + 8'd1; m_phase <= 2; end
        2: begin
          m_op <= m_ir[7:6]; m_operand <= m_ir[5:0];
          m_phase <= (m_ir[7:6] == 2'b11) ? 4 : 3;
        end
        3: if (exec_done) m_phase <= 1;
        4: if (start) begin m_pc <= 8'h00; m_phase <= 1; end
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_req",    32'(imem_req),   32'(m_phase == 1));
    chk("m_busy",   32'(busy),       32'(m_phase >= 1 && m_phase <= 3));
    chk("m_halted", 32'(halted),     32'(m_phase == 4));
    chk("m_valid",  32'(ctrl_valid), 32'(m_phase == 3));
    chk("m_ctrl",   32'(ctrl),       (m_phase >= 3) ? 32'(ctrl_word(m_op)) : 32'h0);
    chk("m_operand",32'(operand),    32'(m_operand));
    chk("m_pc",     32'(pc),         32'(m_pc));
    if (m_phase == 1) chk("m_addr", 32'(imem_addr), 32'(m_pc));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin step(); n++; end
    if (!imem_req) chk("req_timeout", 32'(imem_req), 32'd1);
  endtask

  // Delivers one instruction; returns in the first EXEC (or HALT) cycle.
  task automatic do_fetch(input logic [7:0] d);
    wait_req();
    imem_ack = 1'b1; imem_data = d;
    step();
    imem_ack = 1'b0; imem_data = 8'h00;
    step();
  endtask

  // Spurious start during the wait; returns in the following FETCH cycle.
  task automatic do_exec(input int dly);
    int n = 0;
    while (!ctrl_valid && n < 50) begin step(); n++; end
    if (!ctrl_valid) chk("valid_timeout", 32'(ctrl_valid), 32'd1);
    repeat (dly) begin start = 1'b1; step(); end
    start = 1'b0;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);

    // Single instruction, immediate ack and completion
    start = 1'b1; step(); start = 1'b0;
    do_fetch(8'h05);
    chk("t1_ctrl", 32'(ctrl), 32'h0B);
    chk("t1_operand", 32'(operand), 32'd5);
    chk("t1_valid", 32'(ctrl_valid), 32'd1);
    do_exec(0);
    chk("t1_valid_off", 32'(ctrl_valid), 32'd0);
    chk("t1_pc", 32'(pc), 32'd1);
    chk("t1_req", 32'(imem_req), 32'd1);

    // Three-instruction program ending in halt
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    do_fetch(8'h41);
    chk("t2_ctrl0", 32'(ctrl), 32'h66);
    chk("t2_operand0", 32'(operand), 32'd1);
    do_exec(4);
    do_fetch(8'h82);
    chk("t2_ctrl1", 32'(ctrl), 32'h14);
    do_exec(4);
    do_fetch(8'hC0);
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_ctrl_halt", 32'(ctrl), 32'h80);
    chk("t2_valid_halt", 32'(ctrl_valid), 32'd0);
    chk("t2_pc", 32'(pc), 32'd3);

    // Restart from HALT
    start = 1'b1; step(); start = 1'b0;
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_pc", 32'(pc), 32'd0);
    chk("t5_halted", 32'(halted), 32'd0);
    chk("t5_ctrl", 32'(ctrl), 32'h0);

    // Ack withheld 10 cycles, with spurious exec_done meanwhile
    repeat (10) begin exec_done = 1'b1; step(); end
    exec_done = 1'b0;
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", 32'(imem_addr), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_valid", 32'(ctrl_valid), 32'd0);
    do_fetch(8'h3F);
    chk("t3_ctrl", 32'(ctrl), 32'h0B);
    chk("t3_operand", 32'(operand), 32'h3F);
    do_exec(1);

    // Run the pc up to 8'hFF and across the wrap
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      do_fetch({2'(i % 3), iv[5:0]});
      do_exec(0);
    end
    chk("t4_pc_ff", 32'(pc), 32'hFF);
    chk("t4_addr_ff", 32'(imem_addr), 32'hFF);
    do_fetch(8'h00);
    chk("t4_pc_wrap", 32'(pc), 32'h00);
    do_exec(0);

    // Asynchronous reset in the middle of EXEC
    do_fetch(8'h07);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_ctrl", 32'(ctrl), 32'h0);
    chk("t6_valid", 32'(ctrl_valid), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_operand", 32'(operand), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_req", 32'(imem_req), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    do_fetch(8'h41);
    chk("t6_ctrl_after", 32'(ctrl), 32'h66);
    do_exec(0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
